pipe_pc_hazard_ctrl: RTL and testbench
======================================

// Module: pipe_pc_hazard_ctrl
// PURPOSE
//  Sequences the Y86-64 pipeline front end: owns the F_predPC register, selects the fetch PC
//  (predicted, mispredicted-branch recovery, ret return address), and drives stage stall/bubble
//  controls for load-use, ret and mispredict hazards. Latches a sticky HALTED state on a non-AOK
//  writeback status. Sits between the fetch logic and the F/D/E/M/W pipeline registers.
// PARAMETERS
//  RESET_PC   64'h0  value loaded into F_predPC on reset
//  CNT_W      32     width of the saturating performance counters
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-high reset
//  f_icode     in   4      icode of the instruction being fetched
//  f_valC      in   64     constant word of the fetched instruction
//  f_valP      in   64     fall-through address of the fetched instruction
//  D_icode     in   4      icode in Decode register
//  d_srcA      in   4      decode srcA (4'hF = none)
//  d_srcB      in   4      decode srcB (4'hF = none)
//  E_icode     in   4      icode in Execute register
//  E_dstM      in   4      Execute dstM (4'hF = none)
//  e_cnd       in   1      condition result computed in Execute this cycle
//  M_icode     in   4      icode in Memory register
//  M_cnd       in   1      latched condition in Memory register
//  M_valA      in   64     fall-through PC carried by a jump in Memory
//  m_stat      in   3      status produced by Memory stage this cycle
//  W_icode     in   4      icode in Writeback register
//  W_valM      in   64     return address read by a ret, now in Writeback
//  W_stat      in   3      Writeback status (1=AOK 2=HLT 3=ADR 4=INS)
//  f_pc        out  64     PC to fetch this cycle
//  F_stall     out  1      hold F_predPC
//  D_stall     out  1      hold D register
//  D_bubble    out  1      load nop into D
//  E_bubble    out  1      load nop into E
//  M_bubble    out  1      load nop into M
//  W_stall     out  1      hold W register
//  halted      out  1      sticky: pipeline stopped
//  mispred_cnt out  CNT_W  count of mispredicted jumps
//  stall_cnt   out  CNT_W  count of cycles with F_stall=1 while RUN
// BEHAVIOUR
//  icodes: HALT0 NOP1 CMOV2 IRMOV3 RMMOV4 MRMOV5 OP6 JXX7 CALL8 RET9 PUSHA POPB.
//  f_pc (comb): M_icode==JXX && !M_cnd -> M_valA; else W_icode==RET -> W_valM; else F_predPC.
//   Mispredict has priority when both match.
//  pred_pc (comb): f_icode in {JXX,CALL} -> f_valC; else f_valP.
//  F_predPC: reset -> RESET_PC; else if !F_stall -> pred_pc; else hold. Only register on PC path.
//  Hazards (comb): load_use = E_icode in {MRMOV,POP} && E_dstM!=F && E_dstM in {d_srcA,d_srcB};
//   ret_haz = RET in {D_icode,E_icode,M_icode}; mispred = E_icode==JXX && !e_cnd.
//  Controls in RUN: F_stall = load_use|ret_haz; D_stall = load_use;
//   D_bubble = mispred | (ret_haz & !load_use); E_bubble = mispred | load_use;
//   M_bubble = m_stat in {ADR,INS,HLT} | W_stat!=AOK; W_stall = W_stat!=AOK.
//   D_stall and D_bubble never both 1 (load_use wins).
//  FSM: RUN, HALTED. RUN->HALTED on rising edge when W_stat!=AOK. HALTED is absorbing until
//   reset. In HALTED: F_stall=D_stall=W_stall=M_bubble=1, D_bubble=E_bubble=0, halted=1,
//   F_predPC frozen, counters frozen.
//  Counters: mispred_cnt +1 on each RUN cycle with mispred; stall_cnt +1 on each RUN cycle with
//   F_stall; both saturate at all-ones, never wrap.
//  Reset (incl. mid-operation): next edge state=RUN, F_predPC=RESET_PC, counters=0, halted=0;
//   combinational outputs follow inputs immediately after.
//  Latency: f_pc/controls combinational same cycle; F_predPC and state update one edge later.
// TESTING
//  Reset, f_icode=OP, f_valP=0xA -> f_pc=0x0 cycle0, F_predPC=0xA after edge, all controls 0.
//  E_icode=MRMOV,E_dstM=3,d_srcA=3 -> F_stall=D_stall=E_bubble=1,D_bubble=0; F_predPC held 1 cyc.
//  f_icode=JXX,f_valC=0x40; next E:JXX,e_cnd=0 -> D_bubble=E_bubble=1,mispred_cnt=1; then
//   M_icode=JXX,M_cnd=0,M_valA=0x1D -> f_pc=0x1D.
//  RET walks D,E,M -> F_stall=D_bubble=1 three cycles, stall_cnt=3; W_icode=RET,W_valM=0x80 ->
//   f_pc=0x80, F_stall=0.
//  W_stat=ADR -> HALTED next edge, halted=1, F_predPC frozen; reset -> RUN, F_predPC=RESET_PC.
//  CNT_W=4, 20 mispredicts -> mispred_cnt stays 4'hF.

Source files
------------

// File: rtl/pipe_pc_hazard_ctrl_if.sv
// Front-end control bundle between the fetch/pipeline-register logic and the
// PC/hazard controller. The master drives pipeline state; the slave returns the fetch PC and stage controls.
interface pipe_pc_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       f_icode;
  logic [63:0]      f_valC;
  logic [63:0]      f_valP;
  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_cnd;
  logic [3:0]       M_icode;
  logic             M_cnd;
  logic [63:0]      M_valA;
  logic [2:0]       m_stat;
  logic [3:0]       W_icode;
  logic [63:0]      W_valM;
  logic [2:0]       W_stat;

  logic [63:0]      f_pc;
  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             halted;
  logic [CNT_W-1:0] mispred_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output f_icode, f_valC, f_valP, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
           M_icode, M_cnd, M_valA, m_stat, W_icode, W_valM, W_stat,
    input  f_pc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted,
           mispred_cnt, stall_cnt
  );

  modport slave (
    input  f_icode, f_valC, f_valP, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
           M_icode, M_cnd, M_valA, m_stat, W_icode, W_valM, W_stat,
    output f_pc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted,
           mispred_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_pc_hazard_ctrl.sv
// Y86-64 front-end sequencer: owns the predicted PC, picks the fetch PC and raises
// stall/bubble controls for load-use, ret and mispredict hazards; stops for good on a bad writeback status.
module pipe_pc_hazard_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_pc_hazard_ctrl_if.slave bus
);

  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;
  localparam logic [2:0] S_AOK   = 3'd1;
  localparam logic [2:0] S_HLT   = 3'd2;
  localparam logic [2:0] S_ADR   = 3'd3;
  localparam logic [2:0] S_INS   = 3'd4;

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [63:0]      f_pred_pc_p0;
  logic [63:0]      pred_pc;
  logic [CNT_W-1:0] mispred_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic load_use;
  logic ret_haz;
  logic mispred;
  logic w_bad;
  logic m_bad;
  logic run;

  logic f_stall_c;
  logic d_stall_c;
  logic d_bubble_c;
  logic e_bubble_c;
  logic m_bubble_c;
  logic w_stall_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign load_use = ((bus.E_icode == I_MRMOV) || (bus.E_icode == I_POP)) &&
                    (bus.E_dstM != R_NONE) &&
                    ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
  assign ret_haz  = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
  assign mispred  = (bus.E_icode == I_JXX) && !bus.e_cnd;
  assign w_bad    = (bus.W_stat != S_AOK);
  assign m_bad    = (bus.m_stat == S_ADR) || (bus.m_stat == S_INS) || (bus.m_stat == S_HLT);
  assign run      = (state_q == ST_RUN);

  // Fetch PC: a not-taken jump reaching Memory outranks a returning ret in Writeback.
  always_comb begin
    if ((bus.M_icode == I_JXX) && !bus.M_cnd) begin
      bus.f_pc = bus.M_valA;
    end else if (bus.W_icode == I_RET) begin
      bus.f_pc = bus.W_valM;
    end else begin
      bus.f_pc = f_pred_pc_p0;
    end
  end

  always_comb begin
    if ((bus.f_icode == I_JXX) || (bus.f_icode == I_CALL)) begin
      pred_pc = bus.f_valC;
    end else begin
      pred_pc = bus.f_valP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_RUN) && w_bad) begin
      state_d = ST_HALTED;
    end
  end

  always_comb begin
    f_stall_c  = 1'b0;
    d_stall_c  = 1'b0;
    d_bubble_c = 1'b0;
    e_bubble_c = 1'b0;
    m_bubble_c = 1'b0;
    w_stall_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        f_stall_c  = load_use | ret_haz;
        d_stall_c  = load_use;
        d_bubble_c = mispred | (ret_haz & ~load_use);
        e_bubble_c = mispred | load_use;
        m_bubble_c = m_bad | w_bad;
        w_stall_c  = w_bad;
      end
      ST_HALTED: begin
        f_stall_c  = 1'b1;
        d_stall_c  = 1'b1;
        m_bubble_c = 1'b1;
        w_stall_c  = 1'b1;
      end
      default: begin
        f_stall_c = 1'b0;
      end
    endcase
  end

  assign bus.F_stall     = f_stall_c;
  assign bus.D_stall     = d_stall_c;
  assign bus.D_bubble    = d_bubble_c;
  assign bus.E_bubble    = e_bubble_c;
  assign bus.M_bubble    = m_bubble_c;
  assign bus.W_stall     = w_stall_c;
  assign bus.halted      = (state_q == ST_HALTED);
  assign bus.mispred_cnt = mispred_cnt_q;
  assign bus.stall_cnt   = stall_cnt_q;

  // Predicted-PC register and performance counters; all frozen once halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pred_pc_p0  <= RESET_PC;
      mispred_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else if (run) begin
      if (!f_stall_c) begin
        f_pred_pc_p0 <= pred_pc;
      end
      if (mispred) begin
        mispred_cnt_q <= sat_inc(mispred_cnt_q);
      end
      if (f_stall_c) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
    end
  end

endmodule

// File: tb/tb_pipe_pc_hazard_ctrl.sv
// Scoreboard bench for pipe_pc_hazard_ctrl: a behavioural model predicts each cycle's outputs,
// which are queued and compared against the DUT at the falling edge.
module tb_pipe_pc_hazard_ctrl;

  localparam logic [63:0] RST_PC = 64'h100;

  logic clk;
  logic reset;

  pipe_pc_hazard_ctrl_if #(.CNT_W(32)) bus ();
  pipe_pc_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  pipe_pc_hazard_ctrl #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  pipe_pc_hazard_ctrl #(.RESET_PC(RST_PC), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  assign bus4.f_icode = bus.f_icode;
  assign bus4.f_valC  = bus.f_valC;
  assign bus4.f_valP  = bus.f_valP;
  assign bus4.D_icode = bus.D_icode;
  assign bus4.d_srcA  = bus.d_srcA;
  assign bus4.d_srcB  = bus.d_srcB;
  assign bus4.E_icode = bus.E_icode;
  assign bus4.E_dstM  = bus.E_dstM;
  assign bus4.e_cnd   = bus.e_cnd;
  assign bus4.M_icode = bus.M_icode;
  assign bus4.M_cnd   = bus.M_cnd;
  assign bus4.M_valA  = bus.M_valA;
  assign bus4.m_stat  = bus.m_stat;
  assign bus4.W_icode = bus.W_icode;
  assign bus4.W_valM  = bus.W_valM;
  assign bus4.W_stat  = bus.W_stat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] f_pc;
    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic        E_bubble;
    logic        M_bubble;
    logic        W_stall;
    logic        halted;
    logic [31:0] mis;
    logic [31:0] stl;
    logic [3:0]  mis4;
  } obs_t;

  obs_t sb[$];

  int vectors;
  int miscompares;

  logic [63:0] m_pred;
  logic        m_halt;
  logic [31:0] m_mis;
  logic [31:0] m_stl;
  logic [3:0]  m_mis4;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t model_out();
    obs_t e;
    logic lu, rh, mp, wb, mb;
    lu = ((bus.E_icode == 4'h5) || (bus.E_icode == 4'hB)) && (bus.E_dstM != 4'hF) &&
         ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    rh = (bus.D_icode == 4'h9) || (bus.E_icode == 4'h9) || (bus.M_icode == 4'h9);
    mp = (bus.E_icode == 4'h7) && !bus.e_cnd;
    wb = (bus.W_stat != 3'd1);
    mb = (bus.m_stat == 3'd2) || (bus.m_stat == 3'd3) || (bus.m_stat == 3'd4);
    e = '0;
    if ((bus.M_icode == 4'h7) && !bus.M_cnd)  e.f_pc = bus.M_valA;
    else if (bus.W_icode == 4'h9)             e.f_pc = bus.W_valM;
    else                                      e.f_pc = m_pred;
    if (m_halt) begin
      e.F_stall = 1'b1; e.D_stall = 1'b1; e.M_bubble = 1'b1; e.W_stall = 1'b1;
      e.halted = 1'b1;
    end else begin
      e.F_stall  = lu | rh;
      e.D_stall  = lu;
      e.D_bubble = mp | (rh & !lu);
      e.E_bubble = mp | lu;
      e.M_bubble = mb | wb;
      e.W_stall  = wb;
    end
    e.mis  = m_mis;
    e.stl  = m_stl;
    e.mis4 = m_mis4;
    return e;
  endfunction

  task automatic model_step(input obs_t e);
    logic mp;
    mp = (bus.E_icode == 4'h7) && !bus.e_cnd;
    if (!m_halt) begin
      if (!e.F_stall)
        m_pred = ((bus.f_icode == 4'h7) || (bus.f_icode == 4'h8)) ? bus.f_valC : bus.f_valP;
      if (mp && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      if (mp && m_mis4 != 4'hF)         m_mis4 = m_mis4 + 1;
      if (e.F_stall && m_stl != 32'hFFFF_FFFF) m_stl = m_stl + 1;
      if (bus.W_stat != 3'd1) m_halt = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    bus.f_icode = 4'h1; bus.f_valC = 64'h0; bus.f_valP = 64'h0;
    bus.D_icode = 4'h1; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
    bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.e_cnd = 1'b1;
    bus.M_icode = 4'h1; bus.M_cnd = 1'b1; bus.M_valA = 64'h0; bus.m_stat = 3'd1;
    bus.W_icode = 4'h1; bus.W_valM = 64'h0; bus.W_stat = 3'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pred = RST_PC; m_halt = 1'b0; m_mis = '0; m_stl = '0; m_mis4 = '0;
  endtask

  task automatic cycle();
    obs_t e, g;
    sb.push_back(model_out());
    @(negedge clk);
    g.f_pc = bus.f_pc;       g.F_stall = bus.F_stall;   g.D_stall = bus.D_stall;
    g.D_bubble = bus.D_bubble; g.E_bubble = bus.E_bubble; g.M_bubble = bus.M_bubble;
    g.W_stall = bus.W_stall; g.halted = bus.halted;
    g.mis = bus.mispred_cnt; g.stl = bus.stall_cnt;     g.mis4 = bus4.mispred_cnt;
    e = sb.pop_front();
    check("f_pc",        g.f_pc,              e.f_pc);
    check("F_stall",     64'(g.F_stall),      64'(e.F_stall));
    check("D_stall",     64'(g.D_stall),      64'(e.D_stall));
    check("D_bubble",    64'(g.D_bubble),     64'(e.D_bubble));
    check("E_bubble",    64'(g.E_bubble),     64'(e.E_bubble));
    check("M_bubble",    64'(g.M_bubble),     64'(e.M_bubble));
    check("W_stall",     64'(g.W_stall),      64'(e.W_stall));
    check("halted",      64'(g.halted),       64'(e.halted));
    check("mispred_cnt", 64'(g.mis),          64'(e.mis));
    check("stall_cnt",   64'(g.stl),          64'(e.stl));
    check("mispred_cnt4", 64'(g.mis4),        64'(e.mis4));
    @(posedge clk);
    model_step(e);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    idle_inputs();
    do_reset();

    // Plain fall-through fetch: RESET_PC then f_valP.
    bus.f_icode = 4'h6; bus.f_valP = 64'hA;
    cycle();
    bus.f_valP = 64'h14;
    cycle();

    // Load-use on srcA holds F_predPC for one cycle.
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3; bus.f_valP = 64'h20;
    cycle();
    bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.d_srcA = 4'hF;
    cycle();
    // Pop with dstM matching srcB, then dstM=none (no hazard).
    bus.E_icode = 4'hB; bus.E_dstM = 4'h6; bus.d_srcB = 4'h6;
    cycle();
    bus.E_dstM = 4'hF; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
    cycle();
    bus.E_icode = 4'h1;

    // Jump predicted taken, then mispredicted, then recovered from M_valA.
    bus.f_icode = 4'h7; bus.f_valC = 64'h40; bus.f_valP = 64'h1D;
    cycle();
    bus.f_icode = 4'h6; bus.f_valP = 64'h49;
    bus.E_icode = 4'h7; bus.e_cnd = 1'b0;
    cycle();
    bus.E_icode = 4'h1; bus.e_cnd = 1'b1;
    bus.M_icode = 4'h7; bus.M_cnd = 1'b0; bus.M_valA = 64'h1D; bus.f_valP = 64'h26;
    cycle();
    bus.M_icode = 4'h1; bus.M_cnd = 1'b1;

    // Ret walking D, E, M then returning via W_valM.
    bus.f_icode = 4'h9; bus.f_valP = 64'h50;
    cycle();
    bus.f_icode = 4'h1;
    bus.D_icode = 4'h9; cycle();
    bus.D_icode = 4'h1; bus.E_icode = 4'h9; cycle();
    bus.E_icode = 4'h1; bus.M_icode = 4'h9; cycle();
    bus.M_icode = 4'h1; bus.W_icode = 4'h9; bus.W_valM = 64'h80; bus.f_valP = 64'h88;
    cycle();
    bus.W_icode = 4'h1;
    cycle();

    // Load-use and ret together: stall wins over bubble in D.
    bus.E_icode = 4'h5; bus.E_dstM = 4'h2; bus.d_srcA = 4'h2; bus.D_icode = 4'h9;
    cycle();
    idle_inputs();

    // Mispredict in M has priority over ret in W.
    bus.M_icode = 4'h7; bus.M_cnd = 1'b0; bus.M_valA = 64'h300;
    bus.W_icode = 4'h9; bus.W_valM = 64'h400;
    cycle();
    idle_inputs();

    // Mid-operation reset.
    bus.f_icode = 4'h6; bus.f_valP = 64'h777;
    cycle();
    do_reset();
    cycle();

    // Memory-stage error bubbles M without halting.
    bus.m_stat = 3'd3; cycle();
    bus.m_stat = 3'd4; cycle();
    bus.m_stat = 3'd1;

    // Bad writeback status halts; everything frozen until reset.
    bus.W_stat = 3'd3; bus.f_valP = 64'h900;
    cycle();
    bus.W_stat = 3'd1;
    for (int i = 0; i < 3; i++) begin
      bus.f_valP = 64'hA00 + 64'(i);
      bus.E_icode = 4'h7; bus.e_cnd = 1'b0;
      bus.D_icode = (i == 1) ? 4'h9 : 4'h1;
      cycle();
    end
    idle_inputs();
    do_reset();
    bus.f_icode = 4'h6; bus.f_valP = 64'hB0;
    cycle();
    cycle();

    // Twenty back-to-back mispredicts: 4-bit counter saturates at 4'hF.
    bus.E_icode = 4'h7; bus.e_cnd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.f_valP = 64'hC00 + 64'(i * 8);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
